// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: sequential BCD add/subtract controller driving an external
// pipelined BCD adder with a fixed latency of LAT clocks.
// Optional feature macro: BCD_ADDSUB_SEQ_SUB_EN enables subtraction. It adds
// nines'-complement operand preparation and a second pass that re-complements
// a negative result into sign/magnitude form. Without the macro every request
// is an add and neg_o is tied low.
module bcd_addsub_seq #(
    parameter int N   = 33,
    parameter int LAT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_i,
    output logic           ready_o,
    input  logic           op_i,
    input  logic [N*8-1:0] a_i,
    input  logic [N*8-1:0] b_i,
    input  logic           ci_i,
    output logic           done_o,
    output logic [N*8-1:0] o_o,
    output logic           co_o,
    output logic           neg_o,
    output logic [N*8-1:0] add_a_o,
    output logic [N*8-1:0] add_b_o,
    output logic           add_ci_o,
    input  logic [N*8-1:0] add_o_i,
    input  logic           add_co_i
);

    localparam int W  = N * 8;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef BCD_ADDSUB_SEQ_SUB_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            cnt_last;
    logic            in_pass;
    logic            accept;
    logic            pass_end;
    logic            go_pass2;
    logic            last_is_pass2;
    logic [W-1:0]    add_a_q;
    logic [W-1:0]    add_b_q;
    logic            add_ci_q;
    logic [W-1:0]    o_q;
    logic            co_q;
    logic            neg_q;

`ifdef BCD_ADDSUB_SEQ_SUB_EN
    logic            op_q;

    // Per-digit nines' complement (9 - d); digits are assumed to be valid BCD.
    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 2 * N; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction
`else
    logic            unused_op;
    assign unused_op = op_i;
`endif

    assign cnt_last = (cnt == CW'(LAT - 1));

    // State register; reset abandons any operation still in the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        pass_end      = 1'b0;
        go_pass2      = 1'b0;
        in_pass       = 1'b0;
        last_is_pass2 = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    accept     = 1'b1;
                    state_next = PASS1;
                end
            end
            PASS1: begin
                in_pass = 1'b1;
                if (cnt_last) begin
                    pass_end   = 1'b1;
                    state_next = DONE;
`ifdef BCD_ADDSUB_SEQ_SUB_EN
                    if (op_q && !add_co_i) begin
                        go_pass2   = 1'b1;
                        state_next = PASS2;
                    end
`endif
                end
            end
`ifdef BCD_ADDSUB_SEQ_SUB_EN
            PASS2: begin
                in_pass       = 1'b1;
                last_is_pass2 = 1'b1;
                if (cnt_last) begin
                    pass_end   = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latching, pass counter and result capture. The adder inputs
    // only change at acceptance and at the PASS1->PASS2 hand-over, so they
    // stay constant for the full LAT clocks of each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_ci_q <= 1'b0;
            o_q      <= '0;
            co_q     <= 1'b0;
            neg_q    <= 1'b0;
`ifdef BCD_ADDSUB_SEQ_SUB_EN
            op_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt     <= '0;
                add_a_q <= a_i;
`ifdef BCD_ADDSUB_SEQ_SUB_EN
                op_q     <= op_i;
                add_b_q  <= op_i ? nines(b_i) : b_i;
                add_ci_q <= op_i ? 1'b1 : ci_i;
`else
                add_b_q  <= b_i;
                add_ci_q <= ci_i;
`endif
            end else if (go_pass2) begin
                cnt      <= '0;
`ifdef BCD_ADDSUB_SEQ_SUB_EN
                add_a_q  <= nines(add_o_i);
`endif
                add_b_q  <= '0;
                add_ci_q <= 1'b1;
            end else if (in_pass && !cnt_last) begin
                cnt <= cnt + CW'(1);
            end

            if (pass_end && !go_pass2) begin
                o_q   <= add_o_i;
                co_q  <= last_is_pass2 ? 1'b0 : add_co_i;
                neg_q <= last_is_pass2;
            end
        end
    end

    assign ready_o  = (state == IDLE);
    assign done_o   = (state == DONE);
    assign o_o      = o_q;
    assign co_o     = co_q;
    assign neg_o    = neg_q;
    assign add_a_o  = add_a_q;
    assign add_b_o  = add_b_q;
    assign add_ci_o = add_ci_q;

endmodule
